sum_accumulator: RTL
====================

# sum_accumulator

- Sits directly downstream of the team's 4-bit ripple adder.
- Each accepted beat is a {carry-out, sum} word from the adder, zero-extended into a wider running total.
- After COUNT_N beats it presents the total on a valid/ready output with a sticky overflow flag, then starts a new block.
- Turns the adder's per-cycle results into block sums for the verification scoreboard and downstream consumers.

## Interface
Parameters:
- W, 4: adder operand/sum width; input beat is W+1 bits.
- ACC_W, 8: accumulator width; must satisfy ACC_W >= W+1.
- COUNT_N, 4: beats per block; range 1..255.

Ports:
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- clear  in  1: synchronous abort; discards the partial or held block.
- in_valid  in  1: beat present.
- in_ready  out  1: accumulator can take a beat.
- in_sum  in  W: adder sum.
- in_cout  in  1: adder carry-out; forms beat bit W.
- out_valid  out  1: block result valid.
- out_ready  in  1: consumer accepts result.
- out_acc  out  ACC_W: block total, modulo 2^ACC_W.
- out_ovf  out  1: total exceeded 2^ACC_W-1 at some point in this block.

## Operation
- Beat value is {in_cout, in_sum}, zero-extended to ACC_W+1 bits; added to acc in ACC_W+1 bits.
- Bit ACC_W of that sum sets ovf (sticky within the block); acc keeps the low ACC_W bits (wraps).
- FSM states:
  - IDLE: acc=0, cnt=0.
  - ACCUM: 1..COUNT_N-1 beats taken.
  - HOLD: result presented.
- Transitions:
  - IDLE -> ACCUM on the first beat.
  - ACCUM -> HOLD on beat number COUNT_N.
  - HOLD -> IDLE on out_valid && out_ready, which also zeroes acc, cnt and ovf.
  - If COUNT_N=1: IDLE -> HOLD directly.
- in_ready = !rst && state != HOLD (combinational); no same-cycle bypass from the output handshake to input acceptance.
- A beat is taken only on in_valid && in_ready; cycles with in_valid low are bubbles and do not count.
- clear priority: rst > clear > handshakes.
  - clear forces IDLE and zeroes acc, cnt, ovf and out_valid.
  - An input beat or output handshake in the clear cycle is discarded.
- out_acc and out_ovf are registered; they are meaningful only while out_valid=1 and remain stable while out_valid=1 && !out_ready.

## Timing
- Reset values (asynchronous, immediate): state IDLE, acc=0, cnt=0, out_valid=0, out_acc=0, out_ovf=0. in_ready=0 while rst is high and 1 in the first cycle after release.
- Latency: out_valid rises one clk after the edge that takes the COUNT_N-th beat.
- Best-case throughput: COUNT_N beats + 1 HOLD cycle per block, with out_ready held high.
- Backpressure: HOLD lasts until out_ready=1. in_ready=0 throughout, so upstream stalls.
- Reset mid-operation: any state goes to IDLE asynchronously; the partial sum is lost with no output.

## Structure
- Shared header adder_pkg.vh:
  - state encodings IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2;
  - default widths W and ACC_W.
- cnt width is $clog2(COUNT_N+1).
- Single module, no sub-module: one ACC_W+1-bit adder, counter, 3-state FSM. The 4-bit adder stays an upstream instance and is not instantiated here.

## Test plan
Defaults apply unless a test states otherwise.
1. Reset: rst high mid-cycle -> out_valid, out_acc and out_ovf go to 0 and in_ready to 0 immediately; after release, in_ready=1 on the next cycle.
2. Basic block: beats {cout,sum} = 0x05, 0x0A, 0x1F, 0x10, with a 2-cycle bubble after the second beat -> out_acc=0x3E, out_ovf=0, out_valid one cycle after the 4th beat.
3. Overflow: COUNT_N=10, ten beats of 0x1F -> out_acc=0x36, out_ovf=1.
4. Backpressure:
   - Hold out_ready=0 for 5 cycles after out_valid while driving in_valid=1 -> out_valid and out_acc stay stable, in_ready=0, no beat counted.
   - Then raise out_ready -> next cycle out_valid=0, in_ready=1.
5. Clear:
   - Clear after 2 beats, then four beats of 0x01 -> out_acc=0x04, out_ovf=0.
   - Clear asserted in HOLD -> out_valid drops the next cycle.
6. Back-to-back blocks: 8 consecutive beats of 0x01 with out_ready=1 -> two results of 0x04. The 5th beat is taken only after the first HOLD cycle, and no beat is lost or double-counted.

Source files
------------

// File: rtl/sum_accumulator_pkg.sv
// Shared types and default widths for the block-sum accumulator.
//   DEF_W       : adder operand/sum width (input beat is DEF_W+1 bits)
//   DEF_ACC_W   : running-total width
//   DEF_COUNT_N : beats per block
//   state_t     : accumulator FSM encoding
package sum_accumulator_pkg;

    localparam int DEF_W       = 4;
    localparam int DEF_ACC_W   = 8;
    localparam int DEF_COUNT_N = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sum_accumulator_if.sv
// Beat input and block-result output of the accumulator.
//   in_valid/in_ready   : beat handshake, payload {in_cout, in_sum}
//   out_valid/out_ready : result handshake, payload out_acc / out_ovf
// master = upstream adder + downstream consumer side, slave = accumulator.
interface sum_accumulator_if
    import sum_accumulator_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int ACC_W = DEF_ACC_W
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_sum;
    logic             in_cout;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    modport master (
        output in_valid, in_sum, in_cout, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, in_cout, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/sum_accumulator.sv
// Block-sum accumulator behind the 4-bit ripple adder.
// Adds COUNT_N beats of {cout, sum} into an ACC_W-bit total, then presents
// the total and a sticky overflow flag until the consumer accepts it.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   clear : synchronous abort of the partial or held block
//   bus   : beat/result handshakes (sum_accumulator_if.slave)
//
// state | meaning
// IDLE  | acc=0, cnt=0, waiting for the first beat of a block
// ACCUM | 1..COUNT_N-1 beats taken
// HOLD  | block total presented on out_valid, input stalled
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int COUNT_N = DEF_COUNT_N
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    sum_accumulator_if.slave  bus
);
    localparam int              CNT_W    = $clog2(COUNT_N + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT_N - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;

    logic             w_in_ready;
    logic             w_take;
    logic             w_last;
    logic             w_out_hs;
    logic [ACC_W:0]   w_beat;
    logic [ACC_W:0]   w_sum;

    always_comb begin
        w_in_ready = !rst && (r_state != HOLD);
        w_take     = bus.in_valid && w_in_ready;
        w_out_hs   = (r_state == HOLD) && bus.out_ready;
        // cnt holds beats already taken, so this beat is the block's last
        w_last     = (r_cnt == LAST_CNT);
        w_beat     = {{(ACC_W - W){1'b0}}, bus.in_cout, bus.in_sum};
        // one extra bit catches the carry out of the running total
        w_sum      = {1'b0, r_acc} + w_beat;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_take) w_state_nxt = w_last ? HOLD : ACCUM;
            ACCUM:   if (w_take && w_last) w_state_nxt = HOLD;
            HOLD:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (clear) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == HOLD);
            if (clear || w_out_hs) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_take) begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ovf <= r_ovf | w_sum[ACC_W];
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_acc   = r_acc;
    assign bus.out_ovf   = r_ovf;

endmodule
